// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes one RV32I instruction per handshake into an ALU
// control word and operands, issues them to an external combinational ALU
// for one cycle, and presents the captured result on a valid/ready output.
module alu_issue_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic [4:0]      alu_ctl,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_out,
    input  logic            alu_zero,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_taken,
    output logic            out_is_branch,
    output logic            out_illegal,
    output logic [4:0]      out_rd
);

    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
    localparam logic [6:0] F7_ZERO     = 7'b0000000;
    localparam logic [6:0] F7_ALT      = 7'b0100000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_r;
    state_t state_next_s;

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    logic [4:0]      dec_ctl_s;
    logic [XLEN-1:0] dec_a_s;
    logic [XLEN-1:0] dec_b_s;
    logic            dec_illegal_s;
    logic            dec_branch_s;
    logic            accept_s;

    assign opcode_s = instr[6:0];
    assign funct3_s = instr[14:12];
    assign funct7_s = instr[31:25];
    assign accept_s = (state_r == IDLE) && in_valid;

    // Instruction decode: ALU control word, operand selection and legality.
    always_comb begin
        dec_ctl_s     = 5'd0;
        dec_a_s       = rs1_data;
        dec_b_s       = rs2_data;
        dec_illegal_s = 1'b1;
        dec_branch_s  = 1'b0;
        case (opcode_s)
            OPC_OP: begin
                if (funct7_s == F7_ZERO) begin
                    dec_ctl_s     = {2'b00, funct3_s};
                    dec_illegal_s = 1'b0;
                end else if (funct7_s == F7_ALT && funct3_s == 3'b000) begin
                    dec_ctl_s     = 5'd8;
                    dec_illegal_s = 1'b0;
                end else if (funct7_s == F7_ALT && funct3_s == 3'b101) begin
                    dec_ctl_s     = 5'd13;
                    dec_illegal_s = 1'b0;
                end else begin
                    dec_illegal_s = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec_b_s = {{(XLEN-12){instr[31]}}, instr[31:20]};
                case (funct3_s)
                    3'b001: begin
                        // Shift-immediates take only the 5-bit shamt.
                        dec_b_s       = {{(XLEN-5){1'b0}}, instr[24:20]};
                        dec_ctl_s     = 5'd1;
                        dec_illegal_s = (funct7_s != F7_ZERO);
                    end
                    3'b101: begin
                        dec_b_s = {{(XLEN-5){1'b0}}, instr[24:20]};
                        if (funct7_s == F7_ZERO) begin
                            dec_ctl_s     = 5'd5;
                            dec_illegal_s = 1'b0;
                        end else if (funct7_s == F7_ALT) begin
                            dec_ctl_s     = 5'd13;
                            dec_illegal_s = 1'b0;
                        end else begin
                            dec_illegal_s = 1'b1;
                        end
                    end
                    default: begin
                        dec_ctl_s     = {2'b00, funct3_s};
                        dec_illegal_s = 1'b0;
                    end
                endcase
            end
            OPC_BRANCH: begin
                // Codes chosen so that the (optionally inverted) zero flag
                // directly equals the branch outcome.
                dec_branch_s  = 1'b1;
                dec_illegal_s = 1'b0;
                case (funct3_s)
                    3'b000:  dec_ctl_s = 5'd8;
                    3'b001:  dec_ctl_s = 5'd24;
                    3'b100:  dec_ctl_s = 5'd18;
                    3'b101:  dec_ctl_s = 5'd2;
                    3'b110:  dec_ctl_s = 5'd19;
                    3'b111:  dec_ctl_s = 5'd3;
                    default: begin
                        dec_branch_s  = 1'b0;
                        dec_illegal_s = 1'b1;
                    end
                endcase
            end
            OPC_CUSTOM0: begin
                dec_b_s = {XLEN{1'b0}};
                if (funct3_s == 3'b000 && funct7_s == F7_ZERO) begin
                    dec_ctl_s     = 5'd15;
                    dec_illegal_s = 1'b0;
                end else begin
                    dec_illegal_s = 1'b1;
                end
            end
            default: begin
                dec_illegal_s = 1'b1;
            end
        endcase
    end

    // Next-state logic: illegal encodings skip the ALU cycle entirely.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_next_s = dec_illegal_s ? DONE : ISSUE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: begin
                state_next_s = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register plus handshake flags registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            in_ready  <= (state_next_s == IDLE);
            out_valid <= (state_next_s == DONE);
        end
    end

    // Operand issue on accept, result capture at the end of ISSUE.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_ctl       <= 5'd0;
            alu_a         <= {XLEN{1'b0}};
            alu_b         <= {XLEN{1'b0}};
            out_result    <= {XLEN{1'b0}};
            out_taken     <= 1'b0;
            out_is_branch <= 1'b0;
            out_illegal   <= 1'b0;
            out_rd        <= 5'd0;
        end else if (accept_s) begin
            if (dec_illegal_s) begin
                // Operands keep their previous value; only the control word clears.
                alu_ctl       <= 5'd0;
                out_result    <= {XLEN{1'b0}};
                out_taken     <= 1'b0;
                out_is_branch <= 1'b0;
                out_illegal   <= 1'b1;
                out_rd        <= 5'd0;
            end else begin
                alu_ctl       <= dec_ctl_s;
                alu_a         <= dec_a_s;
                alu_b         <= dec_b_s;
                out_is_branch <= dec_branch_s;
                out_illegal   <= 1'b0;
                out_rd        <= dec_branch_s ? 5'd0 : instr[11:7];
            end
        end else if (state_r == ISSUE) begin
            out_result <= alu_out;
            out_taken  <= out_is_branch ? alu_zero : 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: table-driven check of decode, latency and result capture,
// plus hand-written backpressure and mid-operation reset sequences.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  alu_ctl;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_taken;
    logic        out_is_branch;
    logic        out_illegal;
    logic [4:0]  out_rd;

    int checks;
    int errors;

    alu_issue_ctrl #(.XLEN(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instr        (instr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .alu_ctl      (alu_ctl),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_out      (alu_out),
        .alu_zero     (alu_zero),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_taken    (out_taken),
        .out_is_branch(out_is_branch),
        .out_illegal  (out_illegal),
        .out_rd       (out_rd)
    );

    // Clock generation, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural ALU seen by the block (the environment, not a reference model).
    always_comb begin
        alu_out = 32'd0;
        case (alu_ctl[3:0])
            4'd0:  alu_out = alu_a + alu_b;
            4'd1:  alu_out = alu_a << alu_b[4:0];
            4'd2:  alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            4'd3:  alu_out = (alu_a < alu_b) ? 32'd1 : 32'd0;
            4'd4:  alu_out = alu_a ^ alu_b;
            4'd5:  alu_out = alu_a >> alu_b[4:0];
            4'd6:  alu_out = alu_a | alu_b;
            4'd7:  alu_out = alu_a & alu_b;
            4'd8:  alu_out = alu_a - alu_b;
            4'd13: alu_out = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            4'd15: begin
                if ($signed(alu_a) < 0) begin
                    alu_out = 32'd0;
                end else if ($signed(alu_a) > 127) begin
                    alu_out = 32'd127;
                end else begin
                    alu_out = alu_a;
                end
            end
            default: alu_out = 32'd0;
        endcase
        alu_zero = (alu_out == 32'd0) ^ alu_ctl[4];
    end

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  ctl;
        logic        chk_b;
        logic [31:0] b;
        logic [31:0] result;
        logic        taken;
        logic        branch;
        logic        illegal;
        logic [4:0]  rd;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Accept one instruction on the next edge, then check latency and outputs.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        chk({v.name, " in_ready_before"}, {31'd0, in_ready}, 32'd1);
        instr    = v.instr;
        rs1_data = v.rs1;
        rs2_data = v.rs2;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk({v.name, " in_ready_busy"}, {31'd0, in_ready}, 32'd0);
        if (v.illegal) begin
            chk({v.name, " valid_T+1"}, {31'd0, out_valid}, 32'd1);
        end else begin
            chk({v.name, " valid_issue"}, {31'd0, out_valid}, 32'd0);
            if (v.chk_b) begin
                chk({v.name, " alu_b"}, alu_b, v.b);
            end else begin
                chk({v.name, " alu_a"}, alu_a, v.rs1);
            end
            @(negedge clk);
            chk({v.name, " valid_T+2"}, {31'd0, out_valid}, 32'd1);
        end
        chk({v.name, " alu_ctl"}, {27'd0, alu_ctl}, {27'd0, v.ctl});
        chk({v.name, " result"}, out_result, v.result);
        chk({v.name, " taken"}, {31'd0, out_taken}, {31'd0, v.taken});
        chk({v.name, " is_branch"}, {31'd0, out_is_branch}, {31'd0, v.branch});
        chk({v.name, " illegal"}, {31'd0, out_illegal}, {31'd0, v.illegal});
        chk({v.name, " rd"}, {27'd0, out_rd}, {27'd0, v.rd});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({v.name, " valid_drop"}, {31'd0, out_valid}, 32'd0);
        chk({v.name, " in_ready_after"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instr     = 32'd0;
        rs1_data  = 32'd0;
        rs2_data  = 32'd0;

        //          name        instr          rs1           rs2          ctl    chkb  b             result        tk    br    ill   rd
        vecs[0]  = '{"add",     32'h002081B3, 32'd5,        32'd7,       5'd0,  1'b1, 32'd7,        32'd12,       1'b0, 1'b0, 1'b0, 5'd3};
        vecs[1]  = '{"srai",    32'h4040D213, 32'h80000000, 32'd0,       5'd13, 1'b1, 32'd4,        32'hF8000000, 1'b0, 1'b0, 1'b0, 5'd4};
        vecs[2]  = '{"bne",     32'h00209063, 32'd3,        32'd3,       5'd24, 1'b1, 32'd3,        32'd0,        1'b0, 1'b1, 1'b0, 5'd0};
        vecs[3]  = '{"blt",     32'h0020C063, 32'hFFFFFFFF, 32'd1,       5'd18, 1'b1, 32'd1,        32'd1,        1'b1, 1'b1, 1'b0, 5'd0};
        vecs[4]  = '{"bgeu",    32'h0020F063, 32'hFFFFFFFF, 32'd1,       5'd3,  1'b1, 32'd1,        32'd0,        1'b1, 1'b1, 1'b0, 5'd0};
        vecs[5]  = '{"clamp_hi",32'h0000828B, 32'd200,      32'd9,       5'd15, 1'b1, 32'd0,        32'd127,      1'b0, 1'b0, 1'b0, 5'd5};
        vecs[6]  = '{"clamp_lo",32'h0000828B, 32'hFFFFFFFB, 32'd9,       5'd15, 1'b0, 32'd0,        32'd0,        1'b0, 1'b0, 1'b0, 5'd5};
        vecs[7]  = '{"clamp_in",32'h0000828B, 32'd42,       32'd9,       5'd15, 1'b1, 32'd0,        32'd42,       1'b0, 1'b0, 1'b0, 5'd5};
        vecs[8]  = '{"mul",     32'h022081B3, 32'd5,        32'd7,       5'd0,  1'b0, 32'd0,        32'd0,        1'b0, 1'b0, 1'b1, 5'd0};
        vecs[9]  = '{"lui",     32'h123451B7, 32'd5,        32'd7,       5'd0,  1'b0, 32'd0,        32'd0,        1'b0, 1'b0, 1'b1, 5'd0};
        vecs[10] = '{"addi_neg",32'hFFF08393, 32'd10,       32'd0,       5'd0,  1'b1, 32'hFFFFFFFF, 32'd9,        1'b0, 1'b0, 1'b0, 5'd7};
        vecs[11] = '{"sub",     32'h402082B3, 32'd5,        32'd7,       5'd8,  1'b1, 32'd7,        32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 5'd5};
        vecs[12] = '{"slli_bad",32'h40009093, 32'd5,        32'd7,       5'd0,  1'b0, 32'd0,        32'd0,        1'b0, 1'b0, 1'b1, 5'd0};
        vecs[13] = '{"br_f3_2", 32'h0020A063, 32'd5,        32'd7,       5'd0,  1'b0, 32'd0,        32'd0,        1'b0, 1'b0, 1'b1, 5'd0};
        vecs[14] = '{"beq",     32'h00208063, 32'd9,        32'd9,       5'd8,  1'b1, 32'd9,        32'd0,        1'b1, 1'b1, 1'b0, 5'd0};

        // Reset state.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst alu_ctl", {27'd0, alu_ctl}, 32'd0);
        chk("rst alu_a", alu_a, 32'd0);
        chk("rst alu_b", alu_b, 32'd0);
        chk("rst out_result", out_result, 32'd0);
        chk("rst out_flags", {28'd0, out_taken, out_is_branch, out_illegal, 1'b0}, 32'd0);
        chk("rst out_rd", {27'd0, out_rd}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_vec(vecs[i]);
        end

        // Backpressure: result held, new requests ignored while DONE.
        @(negedge clk);
        instr    = 32'h002081B3;
        rs1_data = 32'd5;
        rs2_data = 32'd7;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        instr    = 32'h402082B3;
        rs1_data = 32'd100;
        rs2_data = 32'd1;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk("bp out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp result", out_result, 32'd12);
            chk("bp rd", {27'd0, out_rd}, 32'd3);
            chk("bp alu_ctl", {27'd0, alu_ctl}, 32'd0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp release valid", {31'd0, out_valid}, 32'd0);
        chk("bp release in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp result kept", out_result, 32'd12);

        // Reset while in ISSUE: instruction dropped, no out_valid pulse.
        instr    = 32'h002081B3;
        rs1_data = 32'd1;
        rs2_data = 32'd2;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst_issue pre valid", {31'd0, out_valid}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_issue in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_issue out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_issue result", out_result, 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rst_issue no valid", {31'd0, out_valid}, 32'd0);
            chk("rst_issue idle", {31'd0, in_ready}, 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
